// File: rtl/seg7_capture_if.sv
// Seven-segment reader bus: multiplexed segment/select inputs plus the decoded
// register-file and capture-event outputs.
interface seg7_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    upd;
  logic [2:0]              upd_idx;
  logic                    upd_err;
  logic                    frame_done;

  modport master (
    output seg_in, dig_sel,
    input  digits, digit_valid, digit_err, upd, upd_idx, upd_err, frame_done
  );
  modport slave (
    input  seg_in, dig_sel,
    output digits, digit_valid, digit_err, upd, upd_idx, upd_err, frame_done
  );
endinterface

// File: rtl/seg7_capture.sv
// Debounces a multiplexed active-low seven-segment bus and decodes each slot to hex.
// Optional: define SEG7_BLANK_EN to accept the all-off pattern as a legal blank capture.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  seg7_capture_if.slave bus
);
  localparam int         SW  = NUM_DIGITS + 7;
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  function automatic logic onehot(input logic [NUM_DIGITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) n = n + (v[i] ? 1 : 0);
    return n == 1;
  endfunction

  // {legal, blank, value}
  function automatic logic [5:0] dec7(input logic [6:0] p);
    case (p)
      7'b1000000: dec7 = {2'b10, 4'h0};
      7'b1111001: dec7 = {2'b10, 4'h1};
      7'b0100100: dec7 = {2'b10, 4'h2};
      7'b0110000: dec7 = {2'b10, 4'h3};
      7'b0011001: dec7 = {2'b10, 4'h4};
      7'b0010010: dec7 = {2'b10, 4'h5};
      7'b0000010: dec7 = {2'b10, 4'h6};
      7'b1111000: dec7 = {2'b10, 4'h7};
      7'b0000000: dec7 = {2'b10, 4'h8};
      7'b0010000: dec7 = {2'b10, 4'h9};
      7'b0001000: dec7 = {2'b10, 4'hA};
      7'b0000011: dec7 = {2'b10, 4'hB};
      7'b1000110: dec7 = {2'b10, 4'hC};
      7'b0100001: dec7 = {2'b10, 4'hD};
      7'b0000110: dec7 = {2'b10, 4'hE};
      7'b0001110: dec7 = {2'b10, 4'hF};
`ifdef SEG7_BLANK_EN
      7'b1111111: dec7 = {2'b11, 4'h0};
`endif
      default:    dec7 = 6'b0;
    endcase
  endfunction

  logic [SW-1:0]                 in_vec, smp;
  logic [7:0]                    cnt;
  logic                          done, cap, legal, blank;
  logic [3:0]                    val;
  logic [2:0]                    idx;
  logic [NUM_DIGITS-1:0]         smp_sel, seen, seen_nxt;
  logic                          upd_q, upd_err_q, frame_q;
  logic [2:0]                    upd_idx_q;
  logic [NUM_DIGITS-1:0][3:0]    dig_q;
  logic [NUM_DIGITS-1:0]         vld_q, err_q;

  assign in_vec   = {bus.dig_sel, bus.seg_in};
  assign smp_sel  = smp[SW-1:7];
  assign {legal, blank, val} = dec7(smp[6:0]);
  // Counter sits at STABLE_CYCLES until the sample changes; done keeps it to one capture.
  assign cap      = (cnt == STB) && !done;
  assign seen_nxt = seen | smp_sel;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (smp_sel[i]) idx = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      seen      <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      upd_err_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      smp <= in_vec;
      if (!onehot(bus.dig_sel))  cnt <= '0;
      else if (in_vec != smp)    cnt <= 8'd1;
      else if (cnt < STB)        cnt <= cnt + 8'd1;
      if (in_vec != smp)         done <= 1'b0;
      else if (cap)              done <= 1'b1;
      upd_q     <= cap;
      upd_idx_q <= cap ? idx : 3'd0;
      upd_err_q <= cap && !legal;
      frame_q   <= cap && (&seen_nxt);
      if (cap) seen <= (&seen_nxt) ? '0 : seen_nxt;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        dig_q[g] <= '0;
        vld_q[g] <= 1'b0;
        err_q[g] <= 1'b0;
      end else if (cap && smp_sel[g]) begin
        if (!legal) begin
          vld_q[g] <= 1'b0;
          err_q[g] <= 1'b1;
        end else if (blank) begin
          dig_q[g] <= '0;
          vld_q[g] <= 1'b0;
          err_q[g] <= 1'b0;
        end else begin
          dig_q[g] <= val;
          vld_q[g] <= 1'b1;
          err_q[g] <= 1'b0;
        end
      end
    end
  end

  assign bus.digits      = dig_q;
  assign bus.digit_valid = vld_q;
  assign bus.digit_err   = err_q;
  assign bus.upd         = upd_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.upd_err     = upd_err_q;
  assign bus.frame_done  = frame_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random segment runs against an
// event-level model (each held one-hot pair of length >= S yields one capture).
module tb_seg7_capture;
  localparam int ND = 4;
  localparam int S  = 4;

  typedef struct {
    int         cyc;
    int         idx;
    int         kind;   // 0 legal, 1 illegal, 2 blank
    logic [3:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  ev_t           q[$];
  logic [3:0]    mdig[ND];
  logic [ND-1:0] mv, me, mseen;
  logic [ND-1:0] last_sel;
  logic [6:0]    last_p;

  logic [6:0] pat[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int mdec(input logic [6:0] p);
    for (int v = 0; v < 16; v++) if (pat[v] == p) return v;
`ifdef SEG7_BLANK_EN
    if (p == 7'h7f) return 16;
`endif
    return -1;
  endfunction

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < ND; i++) mdig[i] = 4'h0;
    mv = '0; me = '0; mseen = '0;
  endtask

  task automatic step(input logic [ND-1:0] sel, input logic [6:0] p);
    ev_t             e;
    logic            eu, efd;
    logic [4*ND-1:0] ed;
    bus.dig_sel = sel;
    bus.seg_in  = p;
    @(posedge clk);
    cyc++;
    #1;
    eu = 1'b0; efd = 1'b0;
    e  = '{0, 0, 0, 4'h0};
    if (!rst && q.size() > 0 && q[0].cyc == cyc) begin
      e  = q.pop_front();
      eu = 1'b1;
      mseen[e.idx] = 1'b1;
      if (&mseen) begin efd = 1'b1; mseen = '0; end
      case (e.kind)
        0: begin mdig[e.idx] = e.val; mv[e.idx] = 1'b1; me[e.idx] = 1'b0; end
        1: begin mv[e.idx] = 1'b0; me[e.idx] = 1'b1; end
        default: begin mdig[e.idx] = 4'h0; mv[e.idx] = 1'b0; me[e.idx] = 1'b0; end
      endcase
    end
    for (int i = 0; i < ND; i++) ed[4*i +: 4] = mdig[i];
    chk("upd", 32'(bus.upd), 32'(eu));
    if (eu) begin
      chk("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
      chk("upd_err", 32'(bus.upd_err), 32'(e.kind == 1));
    end
    chk("frame_done", 32'(bus.frame_done), 32'(efd));
    chk("digits", 32'(bus.digits), 32'(ed));
    chk("digit_valid", 32'(bus.digit_valid), 32'(mv));
    chk("digit_err", 32'(bus.digit_err), 32'(me));
  endtask

  task automatic do_reset(input int n, input logic [ND-1:0] sel, input logic [6:0] p);
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < n; i++) step(sel, p);
    rst = 1'b0;
    last_sel = '0;
    last_p   = '0;
  endtask

  task automatic seg(input logic [ND-1:0] sel, input logic [6:0] p, input int len);
    ev_t e;
    int  d;
    if ($onehot(sel) && len >= S) begin
      d = mdec(p);
      e.cyc = cyc + 1 + S;
      e.idx = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) e.idx = i;
      e.kind = (d < 0) ? 1 : ((d == 16) ? 2 : 0);
      e.val  = (e.kind == 0) ? d[3:0] : 4'h0;
      q.push_back(e);
    end
    for (int i = 0; i < len; i++) step(sel, p);
    last_sel = sel;
    last_p   = p;
  endtask

  initial begin
    logic [ND-1:0] rs;
    logic [6:0]    rp;
    int            r;
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    last_sel    = '0;
    last_p      = '0;
    clear_model();

    do_reset(2, '0, '0);
    chk("reset_digits", 32'(bus.digits), 32'h0);

    seg(4'b0001, pat[2], 10);
    chk("legal_digit0", 32'(bus.digits[3:0]), 32'h2);
    seg(4'b0010, pat[2], 3);
    seg(4'b0010, 7'b0101010, 5);
    chk("illegal_err", 32'(bus.digit_err), 32'h2);
    seg(4'b0011, pat[0], 20);
    seg(4'b0000, pat[0], 20);
    seg(4'b1000, pat[9], S);

    do_reset(1, '0, '0);
    seg(4'b0001, pat[7], 6);
    seg(4'b0010, pat[10], 6);
    seg(4'b0100, pat[15], 6);
    seg(4'b1000, pat[0], 6);
    seg(4'b0000, 7'h00, 2);
    chk("frame_digits", 32'(bus.digits), 32'h0FA7);
    chk("frame_valid", 32'(bus.digit_valid), 32'hF);

    seg(4'b0100, 7'h7f, 6);

    seg(4'b0100, pat[3], 2);
    do_reset(1, 4'b0100, pat[3]);
    seg(4'b0100, pat[3], 3);
    seg(4'b0000, 7'h00, 8);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) rs = '0;
      else if (r == 1) begin
        rs = 4'($urandom_range(0, 15));
        if ($onehot(rs) || rs == '0) rs = 4'b1100;
      end else rs = 4'(1 << $urandom_range(0, ND - 1));
      r = $urandom_range(0, 9);
      if (r < 7)       rp = pat[$urandom_range(0, 15)];
      else if (r == 7) rp = 7'h7f;
      else             rp = 7'($urandom_range(0, 127));
      if (rs == last_sel && rp == last_p) rp = rp ^ 7'h01;
      seg(rs, rp, $urandom_range(1, 7));
    end
    seg(4'b0000, 7'h00, S + 2);
    chk("events_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
